mac_dot_sequencer: RTL and testbench
====================================

Name: mac_dot_sequencer

Overview:
- Initiator-side driver for the 14x14 -> 28-bit pipelined saturating MAC.
- Reads one M x N weight matrix and one length-N vector from two sync-read operand memories.
- For each matrix row: clears the MAC, streams N operand pairs with valid_in, then collects the final accumulator f after N valid_out pulses.
- Emits each dot product on a valid/ready output stream; the convolution datapath sits downstream.

Parameters:
- WIDTH, 14, operand width (signed).
- ACC_WIDTH, 28, accumulator width (signed).
- N, 4, dot-product length (MACs per output).
- M, 8, number of outputs (matrix rows).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a job when idle.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last output handshake.
- w_addr  out  clog2(M*N)  weight memory address; row-major, row*N+col.
- x_addr  out  clog2(N)  vector memory address.
- rd_en  out  1  memory read enable; read data appears the next cycle.
- w_rdata  in  WIDTH  weight read data (signed).
- x_rdata  in  WIDTH  vector read data (signed).
- mac_reset  out  1  drives the MAC reset input.
- mac_a  out  WIDTH  MAC operand a (= w_rdata).
- mac_b  out  WIDTH  MAC operand b (= x_rdata).
- mac_valid_in  out  1  MAC valid_in.
- mac_f  in  ACC_WIDTH  MAC accumulator output.
- mac_valid_out  in  1  MAC valid_out.
- y_data  out  ACC_WIDTH  dot-product result (signed).
- y_valid  out  1  result valid.
- y_ready  in  1  downstream accept.

Behaviour:
- Reset values: busy=0, done=0, rd_en=0, mac_valid_in=0, y_valid=0, y_data=0, addresses=0.
- During reset, mac_reset=1 (mac_reset = reset | clear-state).
- FSM states and transitions:
  - IDLE --start--> CLEAR.
  - CLEAR (1 cycle, mac_reset=1, row counter held) -> ISSUE.
  - ISSUE (N cycles, rd_en=1, col 0..N-1, w_addr=row*N+col, x_addr=col) -> DRAIN.
  - DRAIN waits until the count of mac_valid_out pulses since CLEAR equals N -> OUTPUT.
  - OUTPUT holds y_valid until y_ready.
  - On handshake: if row<M-1 then row++ and go to CLEAR; else go to IDLE and pulse done.
- Read latency: mac_valid_in is rd_en delayed by one register. mac_a/mac_b are the memory read data, which is aligned with mac_valid_in by construction.
- Result capture: y_data <= mac_f in the cycle of the Nth mac_valid_out; MAC f and valid_out update on the same edge. y_data is stable while y_valid=1 and y_ready=0.
- The sequencer counts valid_out pulses and has no hard-coded MAC latency, so it works with the 3-stage and 4-stage MAC variants.
- Reference timing with the 4-stage MAC (valid_out 6 cycles after valid_in), start sampled at edge 0:
  - CLEAR in cycle 1; rd_en in cycles 2..N+1; mac_valid_in in cycles 3..N+2.
  - valid_out in cycles 9..N+8; y_valid from cycle N+9. For N=4 that is cycle 13.
- Arithmetic: no arithmetic in this block. Saturation to +/-2^27 bounds is the MAC's job; y_data is passed through bit-exact.
- Boundary conditions:
  - start while busy: ignored.
  - mac_valid_out outside CLEAR..DRAIN: ignored, not counted.
  - Valid-out counter clears in CLEAR.
  - y_valid and y_ready already high on the first OUTPUT cycle: handshake completes that cycle, with no extra bubble beyond the next CLEAR.
  - Reset mid-job: FSM to IDLE, all counters 0, y_valid dropped, no done pulse; the MAC is also cleared via mac_reset.
  - M=1 or N=1 must work; counter widths use clog2(N+1) and clog2(M+1).

Decomposition:
- Package mac_pkg:
  - WIDTH/ACC_WIDTH constants.
  - signed operand_t / acc_t typedefs.
  - state enum seq_state_t {IDLE, CLEAR, ISSUE, DRAIN, OUTPUT}.
- One sub-module, seq_counter: a parameterised modulo counter with clear/enable/terminal-count. It is instantiated for column, row and valid_out counts.
- Bench instantiates the existing MAC top with the 4-stage multiplier as the responder, plus behavioural sync-read memories.

Test Plan:
- N=4, M=2, x=[1,2,3,4], w row0=[1,1,1,1], row1=[-2,3,0,5], y_ready=1 -> y=10 (first y_valid at cycle 13), then y=24; done pulses once; busy low afterwards.
- All operands 8191, N=4 -> MAC saturates; y_data=134217727. Then all w=-8192, x=8191 -> y_data=-134217728.
- y_ready held low 5 cycles on row0 -> y_valid stays high, y_data stays 10; row1 does not start CLEAR until the handshake.
- start pulsed again during ISSUE of row0 -> ignored; exactly M outputs and one done.
- reset asserted during DRAIN of row0, then a fresh start -> outputs restart from row0 with correct values (10, 24); no stale accumulation.
- Spurious mac_valid_out forced in IDLE (bench override) -> no y_valid, counter unaffected; the subsequent job gives correct results.

Source files
------------

// File: rtl/mac_dot_sequencer_pkg.sv
// Shared types and constants for the MAC dot-product sequencer slice.
package mac_pkg;

    localparam int WIDTH     = 14;
    localparam int ACC_WIDTH = 28;

    typedef logic signed [WIDTH-1:0]     operand_t;
    typedef logic signed [ACC_WIDTH-1:0] acc_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ISSUE,
        DRAIN,
        OUTPUT
    } seq_state_t;

    // Address width for a memory of the given depth; never narrower than one bit
    // so a depth-1 memory still has a real address port.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mac_dot_sequencer_if.sv
// Bus bundle between the sequencer and its environment: operand memories,
// the MAC it drives, and the downstream result stream.
interface mac_dot_sequencer_if #(
    parameter int WIDTH     = 14,
    parameter int ACC_WIDTH = 28,
    parameter int N         = 4,
    parameter int M         = 8
);
    localparam int W_AW = mac_pkg::addr_w(M * N);
    localparam int X_AW = mac_pkg::addr_w(N);

    // operand memories (sync read, data one cycle after rd_en)
    logic [W_AW-1:0]      w_addr;
    logic [X_AW-1:0]      x_addr;
    logic                 rd_en;
    logic [WIDTH-1:0]     w_rdata;
    logic [WIDTH-1:0]     x_rdata;

    // MAC drive and response
    logic                 mac_reset;
    logic [WIDTH-1:0]     mac_a;
    logic [WIDTH-1:0]     mac_b;
    logic                 mac_valid_in;
    logic [ACC_WIDTH-1:0] mac_f;
    logic                 mac_valid_out;

    // result stream
    logic [ACC_WIDTH-1:0] y_data;
    logic                 y_valid;
    logic                 y_ready;

    modport master (
        output w_addr, x_addr, rd_en,
        input  w_rdata, x_rdata,
        output mac_reset, mac_a, mac_b, mac_valid_in,
        input  mac_f, mac_valid_out,
        output y_data, y_valid,
        input  y_ready
    );

    modport slave (
        input  w_addr, x_addr, rd_en,
        output w_rdata, x_rdata,
        input  mac_reset, mac_a, mac_b, mac_valid_in,
        output mac_f, mac_valid_out,
        input  y_data, y_valid,
        output y_ready
    );

endinterface

// File: rtl/mac_dot_sequencer_counter.sv
// Modulo counter with synchronous clear (priority) and enable; terminal flags
// the last value before wrap.
module seq_counter #(
    parameter int MODULUS = 4,
    parameter int CW      = $clog2(MODULUS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          terminal
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign count    = count_q;
    assign terminal = (count_q == CW'(MODULUS - 1));

    // next count: clear wins, otherwise advance and wrap at the terminal value
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = terminal ? '0 : count_q + CW'(1);
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mac_dot_sequencer.sv
// Walks an M x N weight matrix against a length-N vector through an external
// pipelined MAC, one row per output. Completion of a row is detected by
// counting MAC valid_out pulses, so any MAC pipeline depth works.
module mac_dot_sequencer #(
    parameter int WIDTH     = mac_pkg::WIDTH,
    parameter int ACC_WIDTH = mac_pkg::ACC_WIDTH,
    parameter int N         = 4,
    parameter int M         = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    mac_dot_sequencer_if.master bus
);
    import mac_pkg::*;

    localparam int W_AW = addr_w(M * N);
    localparam int X_AW = addr_w(N);
    localparam int CW   = $clog2(N + 1);
    localparam int RW   = $clog2(M + 1);

    seq_state_t                  state_q;
    logic                        busy_q;
    logic                        done_q;
    logic                        y_valid_q;
    logic signed [ACC_WIDTH-1:0] y_data_q;
    logic                        mac_valid_in_q;
    logic                        mac_valid_in_d;

    logic [CW-1:0] col_cnt;
    logic          col_tc;
    logic [RW-1:0] row_cnt;
    logic          row_tc;
    logic [CW-1:0] vld_cnt_unused;
    logic          vld_tc;

    logic in_clear;
    logic in_issue;
    logic start_ok;
    logic handshake;
    logic vld_en;

    assign in_clear  = (state_q == CLEAR);
    assign in_issue  = (state_q == ISSUE);
    assign start_ok  = (state_q == IDLE) && start;
    assign handshake = (state_q == OUTPUT) && bus.y_ready;
    // valid_out only belongs to the current row while CLEAR..DRAIN
    assign vld_en    = bus.mac_valid_out &&
                       ((state_q == CLEAR) || (state_q == ISSUE) || (state_q == DRAIN));

    // column within the current row, advanced once per issued read
    seq_counter #(.MODULUS(N), .CW(CW)) u_col_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (in_clear),
        .enable   (in_issue),
        .count    (col_cnt),
        .terminal (col_tc)
    );

    // row index, advanced only on a result handshake that is not the last row
    seq_counter #(.MODULUS(M), .CW(RW)) u_row_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (start_ok),
        .enable   (handshake && !row_tc),
        .count    (row_cnt),
        .terminal (row_tc)
    );

    // MAC results seen since the last clear; terminal marks the Nth one
    seq_counter #(.MODULUS(N), .CW(CW)) u_vld_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (in_clear),
        .enable   (vld_en),
        .count    (vld_cnt_unused),
        .terminal (vld_tc)
    );

    // job sequencing with registered status and result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            y_valid_q <= 1'b0;
            y_data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= CLEAR;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    if (col_tc) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // mac_f already carries the final sum in the Nth valid_out cycle
                    if (vld_en && vld_tc) begin
                        y_data_q  <= bus.mac_f;
                        y_valid_q <= 1'b1;
                        state_q   <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (bus.y_ready) begin
                        y_valid_q <= 1'b0;
                        if (row_tc) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= CLEAR;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // valid_in trails the read enable by the memory read latency
    always_comb begin
        mac_valid_in_d = in_issue;
    end

    // read-latency delay register
    always_ff @(posedge clk) begin
        if (reset) begin
            mac_valid_in_q <= 1'b0;
        end else begin
            mac_valid_in_q <= mac_valid_in_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign bus.rd_en        = in_issue;
    assign bus.w_addr       = W_AW'(int'(row_cnt) * N + int'(col_cnt));
    assign bus.x_addr       = X_AW'(col_cnt);
    assign bus.mac_reset    = reset | in_clear;
    assign bus.mac_a        = bus.w_rdata;
    assign bus.mac_b        = bus.x_rdata;
    assign bus.mac_valid_in = mac_valid_in_q;
    assign bus.y_data       = y_data_q;
    assign bus.y_valid      = y_valid_q;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Self-checking bench: behavioural sync-read memories and a 6-cycle saturating
// MAC responder around the sequencer; table vectors plus corner sequences.
module tb_mac_dot_sequencer;

    localparam int WIDTH     = 14;
    localparam int ACC_WIDTH = 28;
    localparam int N         = 4;
    localparam int M         = 2;
    localparam longint SAT_MAX = 64'sd134217727;
    localparam longint SAT_MIN = -64'sd134217728;
    localparam int NVEC = 9;

    typedef struct packed {
        logic [M*N-1:0][WIDTH-1:0]   w;
        logic [N-1:0][WIDTH-1:0]     x;
        logic [M-1:0][ACC_WIDTH-1:0] y;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy;
    logic done;
    logic spur_vo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_dot_sequencer_if #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .N(N), .M(M)) bus ();

    mac_dot_sequencer #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .N(N), .M(M)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    // behavioural operand memories, one-cycle read latency
    logic signed [WIDTH-1:0] wmem [M*N];
    logic signed [WIDTH-1:0] xmem [N];

    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.w_rdata <= wmem[bus.w_addr];
            bus.x_rdata <= xmem[bus.x_addr];
        end
    end

    function automatic longint sat(input longint v);
        if (v > SAT_MAX) return SAT_MAX;
        if (v < SAT_MIN) return SAT_MIN;
        return v;
    endfunction

    // MAC responder: valid_out six cycles after valid_in, saturating accumulate
    bit [4:0] vpipe;
    longint   ppipe [5];
    longint   f_acc;
    bit       vo;

    always @(posedge clk) begin
        if (bus.mac_reset) begin
            vpipe <= '0;
            f_acc <= 0;
            vo    <= 1'b0;
        end else begin
            vpipe    <= {vpipe[3:0], bus.mac_valid_in};
            ppipe[0] <= longint'($signed(bus.mac_a)) * longint'($signed(bus.mac_b));
            for (int k = 1; k < 5; k++) ppipe[k] <= ppipe[k-1];
            vo <= vpipe[4];
            if (vpipe[4]) f_acc <= sat(f_acc + ppipe[4]);
        end
    end

    assign bus.mac_f         = f_acc[ACC_WIDTH-1:0];
    assign bus.mac_valid_out = vo | spur_vo;

    // reference: saturating dot product of one matrix row with the vector
    function automatic longint ref_dot(input vec_t v, input int row);
        longint acc = 0;
        for (int c = 0; c < N; c++)
            acc = sat(acc + longint'($signed(v.w[row*N+c])) * longint'($signed(v.x[c])));
        return acc;
    endfunction

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // run one job; optional row-0 stall, re-start pulse, or mid-job reset
    task automatic run_job(input vec_t v, input string tag, input int stall,
                           input int restart_cyc, input int abort_cyc, input bit check_timing);
        int cyc = 1;
        int nout = 0;
        int ndone = 0;
        int done_cyc = 0;
        int first_rd = -1;
        int first_yv = -1;
        int stalled = 0;
        logic signed [ACC_WIDTH-1:0] got [M];
        for (int i = 0; i < M*N; i++) wmem[i] = $signed(v.w[i]);
        for (int i = 0; i < N; i++)   xmem[i] = $signed(v.x[i]);
        for (int r = 0; r < M; r++)   got[r] = '0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check($sformatf("%s_busy_c1", tag), busy, 1);
        while (!(ndone > 0 && cyc > done_cyc + 20) && cyc < 400) begin
            if (cyc == abort_cyc) begin
                reset = 1'b1;
                @(negedge clk);
                @(negedge clk);
                check($sformatf("%s_abort_macrst", tag), bus.mac_reset, 1);
                check($sformatf("%s_abort_busy", tag), busy, 0);
                check($sformatf("%s_abort_yvalid", tag), bus.y_valid, 0);
                check($sformatf("%s_abort_rden", tag), bus.rd_en, 0);
                reset = 1'b0;
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    if (done || bus.y_valid || busy) nout++;
                end
                check($sformatf("%s_abort_quiet", tag), nout, 0);
                $display("job %s aborted at cycle %0d", tag, cyc);
                return;
            end
            start = (cyc == restart_cyc);
            bus.y_ready = !(nout == 0 && stalled < stall);
            if (bus.rd_en && first_rd < 0) first_rd = cyc;
            if (bus.y_valid && first_yv < 0) first_yv = cyc;
            if (bus.y_valid && !bus.y_ready) begin
                check($sformatf("%s_stall_hold", tag), $signed(bus.y_data), $signed(v.y[0]));
                check($sformatf("%s_stall_noclear", tag), bus.mac_reset, 0);
                stalled++;
            end
            if (bus.y_valid && bus.y_ready) begin
                if (nout < M) got[nout] = bus.y_data;
                nout++;
            end
            if (done) begin
                ndone++;
                done_cyc = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check($sformatf("%s_nout", tag), nout, M);
        check($sformatf("%s_ndone", tag), ndone, 1);
        check($sformatf("%s_busy_end", tag), busy, 0);
        for (int r = 0; r < M; r++)
            check($sformatf("%s_y%0d", tag, r), got[r], $signed(v.y[r]));
        if (stall > 0) check($sformatf("%s_stalled", tag), stalled, stall);
        if (check_timing) begin
            check($sformatf("%s_first_rden", tag), first_rd, 2);
            check($sformatf("%s_first_yvalid", tag), first_yv, N + 9);
        end
        $display("job %s outputs=%0d y0=%0d y1=%0d done=%0d", tag, nout, got[0], got[M-1], ndone);
    endtask

    vec_t vecs [NVEC];
    int   row1 [N];

    initial begin
        row1 = '{-2, 3, 0, 5};
        // directed vectors with hand-derived results
        for (int c = 0; c < N; c++) begin
            vecs[0].x[c]     = WIDTH'(c + 1);
            vecs[0].w[c]     = WIDTH'(1);
            vecs[0].w[N + c] = WIDTH'(row1[c]);
            vecs[1].x[c]     = WIDTH'(8191);
            vecs[2].x[c]     = WIDTH'(8191);
        end
        for (int i = 0; i < M*N; i++) begin
            vecs[1].w[i] = WIDTH'(8191);
            vecs[2].w[i] = WIDTH'(-8192);
        end
        vecs[0].y[0] = ACC_WIDTH'(10);
        vecs[0].y[1] = ACC_WIDTH'(24);
        for (int r = 0; r < M; r++) begin
            vecs[1].y[r] = ACC_WIDTH'(134217727);
            vecs[2].y[r] = ACC_WIDTH'(-134217728);
        end
        // random vectors scored by the reference model
        for (int v = 3; v < NVEC; v++) begin
            for (int i = 0; i < M*N; i++) vecs[v].w[i] = WIDTH'($urandom);
            for (int c = 0; c < N; c++)   vecs[v].x[c] = WIDTH'($urandom);
            for (int r = 0; r < M; r++)   vecs[v].y[r] = ACC_WIDTH'(ref_dot(vecs[v], r));
        end

        reset = 1'b1;
        start = 1'b0;
        spur_vo = 1'b0;
        bus.y_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rden", bus.rd_en, 0);
        check("rst_vin", bus.mac_valid_in, 0);
        check("rst_yvalid", bus.y_valid, 0);
        check("rst_ydata", bus.y_data, 0);
        check("rst_waddr", bus.w_addr, 0);
        check("rst_xaddr", bus.x_addr, 0);
        check("rst_macrst", bus.mac_reset, 1);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < NVEC; v++)
            run_job(vecs[v], $sformatf("vec%0d", v), 0, -1, -1, v == 0);

        run_job(vecs[0], "stall", 5, -1, -1, 1'b0);
        run_job(vecs[0], "restart", 0, 3, -1, 1'b0);
        run_job(vecs[0], "abort", 0, -1, 8, 1'b0);
        run_job(vecs[0], "after_abort", 0, -1, -1, 1'b0);

        // spurious MAC results while idle must be ignored
        spur_vo = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("spur_yvalid", bus.y_valid, 0);
            check("spur_busy", busy, 0);
        end
        spur_vo = 1'b0;
        run_job(vecs[3], "after_spur", 0, -1, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
